// File: rtl/i2c_fifo_pkg.sv
// Shared constants for the I2C controller byte FIFOs.
// Status-bit indices match the register-slave status register.
package i2c_fifo_pkg;

   localparam int FIFO_DATAWIDTH = 8;
   localparam int FIFO_DEPTH     = 16;
   localparam int FIFO_PTRWIDTH  = 4;
   localparam int FIFO_AF_LEVEL  = 14;

   localparam int TX_FULL  = 7;
   localparam int TX_EMPTY = 6;
   localparam int RX_FULL  = 5;
   localparam int RX_EMPTY = 4;

   typedef enum logic [1:0] {
      FIFO_OP_NONE  = 2'b00,
      FIFO_OP_WRITE = 2'b01,
      FIFO_OP_READ  = 2'b10,
      FIFO_OP_BOTH  = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
      return fifo_op_e'({rd, wr});
   endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// DEPTH x DATAWIDTH storage, one write port and one registered read port.
// Read returns the pre-write contents when both ports hit one entry.
module i2c_fifo_mem
   import i2c_fifo_pkg::*;
#(
   parameter int DATAWIDTH = FIFO_DATAWIDTH,
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int PTRWIDTH  = FIFO_PTRWIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic [PTRWIDTH-1:0]  waddr_i,
   input  logic [DATAWIDTH-1:0] wdata_i,
   input  logic                 re_i,
   input  logic [PTRWIDTH-1:0]  raddr_i,
   output logic [DATAWIDTH-1:0] rdata_o
);

   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic [DATAWIDTH-1:0] rdata_q;

   // storage array, contents intentionally not reset
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // read data register, holds unless a read is accepted
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/i2c_sync_fifo.sv
// Synchronous byte FIFO used for the I2C TX and RX paths.
// Define I2C_FIFO_STROBE_EDGE_EN for rising-edge strobe detection.
module i2c_sync_fifo
   import i2c_fifo_pkg::*;
#(
   parameter int DATAWIDTH         = FIFO_DATAWIDTH,
   parameter int DEPTH             = FIFO_DEPTH,
   parameter int PTRWIDTH          = FIFO_PTRWIDTH,
   parameter int ALMOST_FULL_LEVEL = FIFO_AF_LEVEL
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic                 write_reset_n,
   input  logic                 read_reset_n,
   input  logic                 write_enable,
   input  logic [DATAWIDTH-1:0] data_in,
   input  logic                 read_enable,
   output logic [DATAWIDTH-1:0] data_out,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 overflow,
   output logic                 underflow,
   output logic [PTRWIDTH:0]    count
);

   localparam logic [PTRWIDTH:0] AF_LVL = (PTRWIDTH+1)'(ALMOST_FULL_LEVEL);
   localparam logic [PTRWIDTH:0] PTR_ONE = (PTRWIDTH+1)'(1);

   logic [PTRWIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [PTRWIDTH:0] rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic     flush;
   logic     wr_req, rd_req;
   logic     wr_ok, rd_ok;
   logic     ptr_full, ptr_empty;
   fifo_op_e op;

   assign flush = ~write_reset_n | ~read_reset_n;

`ifdef I2C_FIFO_STROBE_EDGE_EN
   logic we_prev_q;
   logic re_prev_q;

   // previous strobe levels for the rising-edge detector
   always_ff @(posedge PCLK) begin
      if (PRESET || flush) begin
         we_prev_q <= 1'b0;
         re_prev_q <= 1'b0;
      end else begin
         we_prev_q <= write_enable;
         re_prev_q <= read_enable;
      end
   end

   assign wr_req = write_enable & ~we_prev_q;
   assign rd_req = read_enable & ~re_prev_q;
`else
   assign wr_req = write_enable;
   assign rd_req = read_enable;
`endif

   assign ptr_empty = (wr_ptr_q == rd_ptr_q);
   assign ptr_full  = (wr_ptr_q[PTRWIDTH] != rd_ptr_q[PTRWIDTH]) &&
                      (wr_ptr_q[PTRWIDTH-1:0] == rd_ptr_q[PTRWIDTH-1:0]);

   // accept/reject decisions and next pointer/sticky state
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      wr_ok       = 1'b0;
      rd_ok       = 1'b0;
      op          = FIFO_OP_NONE;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         rd_ok = rd_req & ~ptr_empty;
         wr_ok = wr_req & (~ptr_full | rd_ok);
         op    = fifo_op(wr_ok, rd_ok);
         if (op == FIFO_OP_WRITE || op == FIFO_OP_BOTH) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (op == FIFO_OP_READ || op == FIFO_OP_BOTH) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (wr_req && !wr_ok) begin
            overflow_d = 1'b1;
         end
         if (rd_req && !rd_ok) begin
            underflow_d = 1'b1;
         end
      end
   end

   // pointer and sticky-flag registers
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   i2c_fifo_mem #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH),
      .PTRWIDTH  (PTRWIDTH)
   ) u_mem (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .we_i    (wr_ok & ~PRESET),
      .waddr_i (wr_ptr_q[PTRWIDTH-1:0]),
      .wdata_i (data_in),
      .re_i    (rd_ok & ~PRESET),
      .raddr_i (rd_ptr_q[PTRWIDTH-1:0]),
      .rdata_o (data_out)
   );

   assign count       = wr_ptr_q - rd_ptr_q;
   assign full        = ptr_full;
   assign empty       = ptr_empty;
   assign almost_full = (count >= AF_LVL);
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_i2c_sync_fifo.sv
// Directed bench for i2c_sync_fifo.
// Each operation is a one-cycle strobe followed by an idle cycle.
module tb_i2c_sync_fifo;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       write_reset_n;
   logic       read_reset_n;
   logic       write_enable;
   logic [7:0] data_in;
   logic       read_enable;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       overflow;
   logic       underflow;
   logic [4:0] count;

   int n_err = 0;
   int n_chk = 0;

   i2c_sync_fifo dut (
      .PCLK          (PCLK),
      .PRESET        (PRESET),
      .write_reset_n (write_reset_n),
      .read_reset_n  (read_reset_n),
      .write_enable  (write_enable),
      .data_in       (data_in),
      .read_enable   (read_enable),
      .data_out      (data_out),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .overflow      (overflow),
      .underflow     (underflow),
      .count         (count)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic op(input logic we, input logic re, input logic [7:0] d);
      write_enable = we;
      read_enable  = re;
      data_in      = d;
      tick();
      write_enable = 1'b0;
      read_enable  = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      tick();
   endtask

   initial begin
      PRESET        = 1'b1;
      write_reset_n = 1'b1;
      read_reset_n  = 1'b1;
      write_enable  = 1'b0;
      read_enable   = 1'b0;
      data_in       = 8'h00;
      do_reset();

      check("rst_dout", data_out, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_af", almost_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_udf", underflow, 0);

      for (int i = 0; i < 16; i++) begin
         op(1'b1, 1'b0, 8'(i));
         check("fill_count", count, i + 1);
         check("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
         check("fill_full", full, (i == 15) ? 1 : 0);
      end
      op(1'b1, 1'b0, 8'hAA);
      check("ovf_flag", overflow, 1);
      check("ovf_count", count, 16);

      for (int i = 0; i < 16; i++) begin
         op(1'b0, 1'b1, 8'h00);
         check("drain_data", data_out, i);
      end
      check("drain_empty", empty, 1);
      check("drain_count", count, 0);
      op(1'b0, 1'b1, 8'h00);
      check("udf_flag", underflow, 1);
      check("udf_dout", data_out, 8'h0F);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         op(1'b1, 1'b0, 8'(8'h10 + i));
      end
      check("full2", full, 1);
      op(1'b1, 1'b1, 8'h55);
      check("rw_full_dout", data_out, 8'h10);
      check("rw_full_count", count, 16);
      check("rw_full_ovf", overflow, 0);
      for (int i = 1; i < 16; i++) begin
         op(1'b0, 1'b1, 8'h00);
         check("rw_drain", data_out, 8'h10 + i);
      end
      op(1'b0, 1'b1, 8'h00);
      check("rw_last", data_out, 8'h55);
      check("rw_empty", empty, 1);
      check("rw_udf0", underflow, 0);

      op(1'b1, 1'b1, 8'h33);
      check("rw_emp_count", count, 1);
      check("rw_emp_udf", underflow, 1);
      check("rw_emp_dout", data_out, 8'h55);
      op(1'b0, 1'b1, 8'h00);
      check("rw_emp_rd", data_out, 8'h33);

      for (int m = 0; m < 3; m++) begin
         do_reset();
         op(1'b0, 1'b1, 8'h00);
         for (int i = 0; i < 5; i++) begin
            op(1'b1, 1'b0, 8'(8'h40 + i));
         end
         check("fl_pre_count", count, 5);
         check("fl_pre_udf", underflow, 1);
         write_enable  = 1'b1;
         data_in       = 8'h77;
         write_reset_n = (m != 0);
         read_reset_n  = (m != 1);
         PRESET        = (m == 2);
         tick();
         write_enable  = 1'b0;
         write_reset_n = 1'b1;
         read_reset_n  = 1'b1;
         PRESET        = 1'b0;
         tick();
         check("fl_count", count, 0);
         check("fl_empty", empty, 1);
         check("fl_full", full, 0);
         check("fl_ovf", overflow, 0);
         check("fl_udf", underflow, 0);
         check("fl_dout", data_out, 0);
         op(1'b1, 1'b0, 8'h01);
         op(1'b0, 1'b1, 8'h00);
         check("fl_next", data_out, 8'h01);
      end

      do_reset();
      write_enable = 1'b1;
      data_in      = 8'h9C;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      write_enable = 1'b0;
      tick();
`ifdef I2C_FIFO_STROBE_EDGE_EN
      check("hold_count", count, 1);
`else
      check("hold_count", count, 4);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/i2c_sync_fifo.md
Name: i2c_sync_fifo

Overview:
- Synchronous byte FIFO directly downstream of the APB register slave.
- One instance is the TX FIFO: written from the transmit register/write strobe, read by the I2C engine.
- A second instance is the RX FIFO: written by the I2C engine, read via the receive-register read strobe.
- Supplies the full/empty/overflow status that the register slave reflects into its status register.

Parameters:
- DATAWIDTH, 8, width of each FIFO entry.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTRWIDTH, 4, log2(DEPTH); pointers carry one extra wrap bit (PTRWIDTH+1 bits).
- ALMOST_FULL_LEVEL, 14, count at or above which almost_full asserts.

Ports:
- PCLK  input  1  single clock for both sides.
- PRESET  input  1  synchronous, active-high reset.
- write_reset_n  input  1  active-low flush/hold of the write side (command bit).
- read_reset_n  input  1  active-low flush/hold of the read side (command bit).
- write_enable  input  1  write strobe.
- data_in  input  DATAWIDTH  write data.
- read_enable  input  1  read strobe.
- data_out  output  DATAWIDTH  registered read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_LEVEL.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- count  output  PTRWIDTH+1  current number of entries.

Behaviour:
- One clock is used, PCLK. Reset PRESET is synchronous and active-high; all state changes on the PCLK rising edge.
- Reset values: data_out 0, count 0, empty 1, full 0, almost_full 0, overflow 0, underflow 0. Both pointers are 0.
- Memory contents are not reset.
- Flush: in any cycle where write_reset_n or read_reset_n is low, and PRESET is low:
  - both pointers go to 0;
  - overflow and underflow clear;
  - strobes that cycle are ignored;
  - data_out holds its value.
- Write accepted when write_enable is high and the FIFO is not full, or when full with an accepted read in the same cycle:
  - mem[wr_ptr] <= data_in; wr_ptr increments, wrapping modulo 2*DEPTH.
- Write while full with no read: data is dropped, overflow <= 1, pointers unchanged.
- Read accepted when read_enable is high and the FIFO is not empty:
  - data_out <= mem[rd_ptr], visible the cycle after the strobe (1-cycle latency);
  - rd_ptr increments.
- Read while empty: data_out holds, underflow <= 1.
- Simultaneous read and write:
  - Empty: write accepted, read rejected, underflow <= 1; data is not bypassed.
  - Full: both accepted, count stays at DEPTH.
  - Otherwise: both accepted, count unchanged.
- Flags are derived from the post-update pointers:
  - full when the wrap bits differ and the index bits are equal;
  - empty when the pointers are equal;
  - count = wr_ptr - rd_ptr, (PTRWIDTH+1)-bit arithmetic.
- Strobe semantics without the optional feature: level. Each cycle the strobe is high counts as one operation. The driver guarantees one-cycle pulses.
- Reset or flush mid-burst: the operation in that cycle is discarded; the next cycle behaves as freshly empty.

Optional Feature:
- Macro I2C_FIFO_STROBE_EDGE_EN.
- Defined:
  - write_enable and read_enable pass through a rising-edge detector (registered previous value, reset 0).
  - A strobe held high for N cycles performs exactly one operation, on the first cycle.
  - Operation latency does not change.
  - The previous-value registers clear on PRESET and on flush.
- Undefined: level semantics as in Behaviour; no extra registers.

Decomposition:
- Package i2c_fifo_pkg holds:
  - constants FIFO_DATAWIDTH = 8, FIFO_DEPTH = 16, FIFO_PTRWIDTH = 4;
  - status-bit index constants matching the register map: TX_FULL 7, TX_EMPTY 6, RX_FULL 5, RX_EMPTY 4.
- One natural sub-module: i2c_fifo_mem, the DEPTH x DATAWIDTH storage array with one write port and one registered read port.
- Pointer logic, flags and the edge detect stay in i2c_sync_fifo.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F (one-cycle pulses) -> full=1, count=16, almost_full asserted from count 14. A 17th write of 0xAA sets overflow=1, count stays 16.
- Drain 16 reads -> data_out = 0x00..0x0F, each one cycle after its strobe; then empty=1. A 17th read sets underflow=1 and data_out stays 0x0F.
- Full FIFO, simultaneous write 0x55 and read -> data_out = oldest entry, count stays 16, no overflow. Then drain: 0x55 comes out last.
- Empty FIFO, simultaneous write 0x33 and read -> count=1, underflow=1, data_out unchanged. Next read -> data_out=0x33.
- 5 entries loaded, write_reset_n pulsed low for 1 cycle alongside a write of 0x77 -> count=0, empty=1, flags cleared, 0x77 not stored. Repeat with read_reset_n and with PRESET; all give the same result.
- I2C_FIFO_STROBE_EDGE_EN defined, write_enable held high 4 cycles with data 0x9C -> count=1. Undefined, same stimulus -> count=4.
